// File: rtl/apu_pkg.sv
// Shared definitions for the APU frame sequencer: channel count, FSM states,
// step constants and the per-step tick mask table.
package apu_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned NUM_STEPS = 8;
    localparam int unsigned STEP_W    = 3;

    localparam logic [STEP_W-1:0] STEP_FIRST = 3'd0;
    localparam logic [STEP_W-1:0] STEP_LAST  = 3'd7;

    // Tick vector bit positions
    localparam int unsigned TICK_W     = 3;
    localparam int unsigned TICK_LEN   = 0;
    localparam int unsigned TICK_SWEEP = 1;
    localparam int unsigned TICK_ENV   = 2;

    typedef enum logic {OFF, RUN} frame_state_t;

    // Index = step; bits = {env, sweep, length}
    localparam logic [NUM_STEPS-1:0][TICK_W-1:0] TICK_MASK = {
        3'b100,  // step 7: envelope
        3'b011,  // step 6: length + sweep
        3'b000,  // step 5
        3'b001,  // step 4: length
        3'b000,  // step 3
        3'b011,  // step 2: length + sweep
        3'b000,  // step 1
        3'b001   // step 0: length
    };

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Control/status bundle between the APU register file and the frame sequencer.
interface apu_frame_sequencer_if;
    import apu_pkg::*;

    logic              master_en;
    logic [NUM_CH-1:0] trig_req;
    logic [NUM_CH-1:0] length_expired;
    logic              length_tick;
    logic              sweep_tick;
    logic              env_tick;
    logic [STEP_W-1:0] step;
    logic [NUM_CH-1:0] ch_trigger;
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] ch_reset;
    logic [7:0]        nr52_status;

    // Register-file side
    modport master (
        output master_en, trig_req, length_expired,
        input  length_tick, sweep_tick, env_tick, step, ch_trigger, ch_active, ch_reset,
               nr52_status
    );

    // Sequencer side
    modport slave (
        input  master_en, trig_req, length_expired,
        output length_tick, sweep_tick, env_tick, step, ch_trigger, ch_active, ch_reset,
               nr52_status
    );

endinterface

// File: rtl/apu_prescaler.sv
// Frame prescaler: counts 0..FRAME_DIV-1 and flags the last count with wrap.
// clear holds the count at zero (sequencer not running next cycle).
module apu_prescaler #(
    parameter int unsigned FRAME_DIV = 8
) (
    input  logic clk_100,
    input  logic reset,
    input  logic clear,
    output logic wrap
);

    localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign wrap = !clear && (count_q == CNT_LAST);

    // Next count: restart on clear or wrap, otherwise increment
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || wrap) begin
            count_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk_100) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: OFF/RUN control, 8-step frame counter driving the
// length/sweep/envelope clocks, and per-channel trigger/active tracking.
// Build option: define APU_STATUS_READBACK_EN to drive nr52_status from a
// registered master enable and the channel active flags; otherwise it reads 0.
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned FRAME_HZ = 512
) (
    input logic                  clk_100,
    input logic                  reset,
    apu_frame_sequencer_if.slave bus
);

    localparam int unsigned FRAME_DIV = CLK_HZ / FRAME_HZ;

    frame_state_t      state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] trig_q, trig_d;
    logic [NUM_CH-1:0] active_q, active_d;
    logic              run_next;
    logic              wrap;

    // Staying in RUN this cycle; anything else leaves the datapath at OFF values
    assign run_next = (state_q == RUN) && bus.master_en;

    apu_prescaler #(
        .FRAME_DIV (FRAME_DIV)
    ) u_prescaler (
        .clk_100 (clk_100),
        .reset   (reset),
        .clear   (!run_next),
        .wrap    (wrap)
    );

    // Next state, step counter, ticks and channel flags
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        tick_d   = '0;
        trig_d   = '0;
        active_d = active_q;
        unique case (state_q)
            OFF: begin
                step_d   = STEP_FIRST;
                active_d = '0;
                if (bus.master_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.master_en) begin
                    // Triggers seen as the master enable drops are discarded
                    state_d  = OFF;
                    step_d   = STEP_FIRST;
                    active_d = '0;
                end else begin
                    trig_d   = bus.trig_req;
                    // Trigger wins over a simultaneous length expiry
                    active_d = (active_q & ~bus.length_expired) | bus.trig_req;
                    if (wrap) begin
                        tick_d = TICK_MASK[step_q];
                        step_d = (step_q == STEP_LAST) ? STEP_FIRST : step_q + STEP_W'(1);
                    end
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q  <= OFF;
            step_q   <= STEP_FIRST;
            tick_q   <= '0;
            trig_q   <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            trig_q   <= trig_d;
            active_q <= active_d;
        end
    end

    assign bus.length_tick = tick_q[TICK_LEN];
    assign bus.sweep_tick  = tick_q[TICK_SWEEP];
    assign bus.env_tick    = tick_q[TICK_ENV];
    assign bus.step        = step_q;
    assign bus.ch_trigger  = trig_q;
    assign bus.ch_active   = active_q;
    assign bus.ch_reset    = (state_q == OFF) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

`ifdef APU_STATUS_READBACK_EN
    logic master_en_q;

    // Registered master enable for the status image
    always_ff @(posedge clk_100) begin
        if (reset) begin
            master_en_q <= 1'b0;
        end else begin
            master_en_q <= bus.master_en;
        end
    end

    assign bus.nr52_status = {master_en_q, 3'b000, active_q};
`else
    assign bus.nr52_status = 8'h00;
`endif

endmodule

// File: doc/apu_frame_sequencer.md
APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, 100_000_000, system clock frequency.
REQ-002 SHALL have parameter FRAME_HZ, 512, frame-sequencer step rate; FRAME_DIV = CLK_HZ/FRAME_HZ (integer division, remainder dropped), FRAME_DIV >= 2.
REQ-003 SHALL have port clk_100  input  1  system clock; the single clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port master_en  input  1  sound master enable (NR52 bit 7), level.
REQ-006 SHALL have port trig_req  input  4  per-channel trigger request pulse (NRx4 bit-7 write), bit i = channel i+1.
REQ-007 SHALL have port length_expired  input  4  per-channel length counter reached zero, pulse.
REQ-008 SHALL have port length_tick  output  1  256 Hz length-clock pulse.
REQ-009 SHALL have port sweep_tick  output  1  128 Hz sweep-clock pulse (channel 1).
REQ-010 SHALL have port env_tick  output  1  64 Hz envelope-clock pulse.
REQ-011 SHALL have port step  output  3  current frame step 0..7.
REQ-012 SHALL have port ch_trigger  output  4  per-channel one-cycle trigger strobe.
REQ-013 SHALL have port ch_active  output  4  per-channel playing flag.
REQ-014 SHALL have port ch_reset  output  4  per-channel hold-in-reset, level.
REQ-015 SHALL have port nr52_status  output  8  NR52 read-back image.

Function
REQ-016 SHALL implement FSM states OFF and RUN; OFF->RUN when master_en=1, RUN->OFF when master_en=0, evaluated each cycle.
REQ-017 In OFF SHALL hold prescaler=0, step=0, ch_active=0, ch_reset=4'b1111, all tick outputs 0, and ignore trig_req and length_expired.
REQ-018 In RUN SHALL drive ch_reset=4'b0000 and count prescaler 0..FRAME_DIV-1, wrapping to 0.
REQ-019 On the cycle prescaler==FRAME_DIV-1 in RUN SHALL pulse the ticks for the current step for exactly one cycle and advance step modulo 8 (7 wraps to 0).
REQ-020 length_tick SHALL fire on steps 0,2,4,6; sweep_tick on steps 2,6; env_tick on step 7; nothing on steps 1,3,5.
REQ-021 After OFF->RUN the first tick (length_tick, step 0) SHALL occur exactly FRAME_DIV cycles after the first RUN cycle.
REQ-022 trig_req bit i sampled high in RUN SHALL produce ch_trigger[i]=1 on the next cycle only, and set ch_active[i] in that same cycle.
REQ-023 length_expired[i] sampled high in RUN SHALL clear ch_active[i] on the next cycle.
REQ-024 trig_req[i] and length_expired[i] high in the same cycle: trigger SHALL win (ch_active[i]=1, ch_trigger[i] pulses).
REQ-025 trig_req held high N cycles SHALL produce N consecutive ch_trigger pulses; channels SHALL be independent (any subset simultaneously).
REQ-026 trig_req in the cycle master_en falls SHALL be discarded; no ch_trigger in OFF.
REQ-027 Tick outputs and ch_trigger SHALL be registered (no combinational path from inputs).

Reset
REQ-028 reset SHALL force state OFF, prescaler=0, step=0, ch_trigger=0, ch_active=0, all ticks=0, ch_reset=4'b1111, nr52_status=0 on the next edge, overriding all inputs.
REQ-029 reset mid-frame SHALL discard any pending trigger and prescaler progress; counting restarts per REQ-021 after release.

Configuration
REQ-030 Macro APU_STATUS_READBACK_EN: defined -> nr52_status = {master_en_registered, 3'b000, ch_active} updated each cycle; undefined -> nr52_status tied to 8'h00 and its register removed; port exists in both builds.

Structure
REQ-031 Shared package apu_pkg SHALL hold NUM_CH=4, the frame_state_t enum (OFF, RUN), step constants and the per-step tick mask table.
REQ-032 Prescaler SHALL be a sub-module apu_prescaler (parameter FRAME_DIV, inputs clk_100/reset/clear, output wrap pulse); FSM, step counter and trigger logic stay in apu_frame_sequencer.

Verification (CLK_HZ=4096, FRAME_HZ=512, FRAME_DIV=8)
REQ-033 Reset then master_en=1 for 64 cycles -> ticks at RUN cycles 8,16,...,64; pattern L,-,L+S,-,L,-,L+S,E; step wraps 7->0.
REQ-034 trig_req=4'b0101 one cycle -> next cycle ch_trigger=4'b0101, ch_active=4'b0101; nr52_status=8'h85 with APU_STATUS_READBACK_EN, 8'h00 without.
REQ-035 ch_active=4'b1111, length_expired=4'b0010 and trig_req=4'b0011 same cycle -> ch_active=4'b1111, ch_trigger=4'b0011.
REQ-036 master_en dropped at step 5 with trig_req=4'b1000 same cycle -> no ch_trigger, ch_active=0, ch_reset=4'b1111, step=0; re-enable -> first length_tick 8 cycles later.
REQ-037 reset asserted at prescaler=5 with trig_req pending -> all outputs at reset values next cycle; no stray ch_trigger after release.
